// File: rtl/enigma_pkg.sv
// Shared constants and FSM state encoding for the Enigma keystroke controller.
package enigma_pkg;
  localparam int LETTERS = 26;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] INVALID_IDX = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    STEP_HI,
    STEP_LO,
    DRIVE,
    SAMPLE,
    PRESENT
  } keyer_state_t;
endpackage

// File: rtl/onehot_to_index.sv
// Decodes the letter returned by the rotor stack into an index and flags whether
// exactly one line was set.
module onehot_to_index
  import enigma_pkg::*;
(
  input  logic [LETTERS-1:0] vec,
  output logic [IDX_W-1:0]   index,
  output logic               exactly_one
);

  logic [IDX_W-1:0] ones;

  always_comb begin
    ones  = '0;
    index = '0;
    for (int i = 0; i < LETTERS; i++) begin
      if (vec[i]) begin
        ones  = ones + IDX_W'(1);
        index = IDX_W'(i);
      end
    end
    exactly_one = (ones == IDX_W'(1));
  end

endmodule

// File: rtl/enigma_keyer.sv
// Keystroke controller: steps the rotors (with double-step), drives the letter through
// the stack and presents the decoded lamp. Optional KEYER_CHAR_COUNT_EN adds char_count.
//
// state   | meaning
// IDLE    | waiting for a key, key_ready high
// STEP_HI | rotate pulses high for PULSE_WIDTH cycles
// STEP_LO | all rotate pulses low for one cycle
// DRIVE   | one-hot letter on rotor_in for SETTLE_CYCLES cycles
// SAMPLE  | rotor_out decoded into the lamp registers
// PRESENT | lamp_valid high until lamp_ready
module enigma_keyer
  import enigma_pkg::*;
#(
  parameter int PULSE_WIDTH   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [IDX_W-1:0]   key_index,
  input  logic               notch_r,
  input  logic               notch_m,
  output logic               rotate_r,
  output logic               rotate_m,
  output logic               rotate_l,
  output logic [LETTERS-1:0] rotor_in,
  input  logic [LETTERS-1:0] rotor_out,
  output logic               lamp_valid,
  input  logic               lamp_ready,
  output logic [IDX_W-1:0]   lamp_index,
  output logic               lamp_error
`ifdef KEYER_CHAR_COUNT_EN
  ,
  output logic [15:0]        char_count
`endif
);

  keyer_state_t     state, state_nxt;
  logic [15:0]      tmr;
  logic [IDX_W-1:0] key;
  logic             n_r, n_m;
  logic [IDX_W-1:0] dec_index;
  logic             dec_one;
  logic             key_bad;
  logic             tmr_tc;

  assign key_bad = (key_index >= IDX_W'(LETTERS));
  assign tmr_tc  = (tmr == 16'd0);

  onehot_to_index u_dec (
    .vec        (rotor_out),
    .index      (dec_index),
    .exactly_one(dec_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are decoded from state so a reset kills pulses and drive immediately.
  always_comb begin
    state_nxt  = state;
    key_ready  = 1'b0;
    rotate_r   = 1'b0;
    rotate_m   = 1'b0;
    rotate_l   = 1'b0;
    rotor_in   = '0;
    lamp_valid = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = key_bad ? PRESENT : STEP_HI;
      end
      STEP_HI: begin
        rotate_r = 1'b1;
        rotate_m = n_r | n_m;
        rotate_l = n_m;
        if (tmr_tc) state_nxt = STEP_LO;
      end
      STEP_LO: state_nxt = DRIVE;
      DRIVE: begin
        rotor_in = LETTERS'(1) << key;
        if (tmr_tc) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        rotor_in  = LETTERS'(1) << key;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        lamp_valid = 1'b1;
        if (lamp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr        <= '0;
      key        <= '0;
      n_r        <= 1'b0;
      n_m        <= 1'b0;
      lamp_index <= '0;
      lamp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key <= key_index;
            n_r <= notch_r;
            n_m <= notch_m;
            tmr <= 16'(PULSE_WIDTH - 1);
            if (key_bad) begin
              lamp_index <= INVALID_IDX;
              lamp_error <= 1'b1;
            end
          end
        end
        STEP_HI: if (!tmr_tc) tmr <= tmr - 16'd1;
        STEP_LO: tmr <= 16'(SETTLE_CYCLES - 1);
        DRIVE:   if (!tmr_tc) tmr <= tmr - 16'd1;
        SAMPLE: begin
          lamp_index <= dec_one ? dec_index : INVALID_IDX;
          lamp_error <= !dec_one;
        end
        default: ;
      endcase
    end
  end

`ifdef KEYER_CHAR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              char_count <= '0;
    else if (state == PRESENT && lamp_ready) char_count <= char_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_enigma_keyer.sv
// Directed bench for enigma_keyer; build with KEYER_CHAR_COUNT_EN defined to also
// cover char_count.
module tb_enigma_keyer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic        key_ready;
  logic [4:0]  key_index;
  logic        notch_r, notch_m;
  logic        rotate_r, rotate_m, rotate_l;
  logic [25:0] rotor_in;
  logic [25:0] rotor_out;
  logic        lamp_valid;
  logic        lamp_ready;
  logic [4:0]  lamp_index;
  logic        lamp_error;
`ifdef KEYER_CHAR_COUNT_EN
  logic [15:0] char_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  enigma_keyer dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_index (key_index),
    .notch_r   (notch_r),
    .notch_m   (notch_m),
    .rotate_r  (rotate_r),
    .rotate_m  (rotate_m),
    .rotate_l  (rotate_l),
    .rotor_in  (rotor_in),
    .rotor_out (rotor_out),
    .lamp_valid(lamp_valid),
    .lamp_ready(lamp_ready),
    .lamp_index(lamp_index),
    .lamp_error(lamp_error)
`ifdef KEYER_CHAR_COUNT_EN
    ,
    .char_count(char_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one key, observe every cycle until lamp_valid, then check the result.
  // lat is the 1-based cycle after the accept edge in which lamp_valid is first high.
  task automatic run_key(input string name, input logic [4:0] k, input logic nr, input logic nm,
                         input logic [25:0] ret, input logic [25:0] exp_rin,
                         input int exp_r, input int exp_m, input int exp_l,
                         input logic [4:0] exp_idx, input logic exp_err,
                         input int exp_lat, input int exp_drive);
    int cr = 0, cm = 0, cl = 0, cd = 0, lat = 0, bad_sim = 0, bad_rin = 0;
    @(negedge clk);
    rotor_out = ret;
    key_index = k;
    notch_r   = nr;
    notch_m   = nm;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    notch_r   = ~nr;
    notch_m   = ~nm;
    for (int c = 1; c <= 20; c++) begin
      if (lamp_valid) begin
        lat = c;
        break;
      end
      if (rotate_r) begin
        cr++;
        if (rotate_m !== (exp_m != 0) || rotate_l !== (exp_l != 0)) bad_sim++;
      end
      if (rotate_m) cm++;
      if (rotate_l) cl++;
      if (rotor_in != 26'h0) begin
        cd++;
        if (rotor_in !== exp_rin) bad_rin++;
      end
      @(posedge clk);
      #1;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " rotate_r pulses"}, cr, exp_r);
    check({name, " rotate_m pulses"}, cm, exp_m);
    check({name, " rotate_l pulses"}, cl, exp_l);
    check({name, " rotate simultaneous"}, bad_sim, 0);
    check({name, " rotor_in cycles"}, cd, exp_drive);
    check({name, " rotor_in value"}, bad_rin, 0);
    check({name, " lamp_index"}, lamp_index, exp_idx);
    check({name, " lamp_error"}, lamp_error, exp_err);
    check({name, " key_ready in PRESENT"}, key_ready, 0);
    check({name, " rotor_in in PRESENT"}, rotor_in, 0);
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    lamp_ready = 1'b1;
    @(posedge clk);
    #1;
    lamp_ready = 1'b0;
    exp_cnt++;
    check({name, " lamp_valid after ack"}, lamp_valid, 0);
    check({name, " key_ready after ack"}, key_ready, 1);
`ifdef KEYER_CHAR_COUNT_EN
    check({name, " char_count"}, char_count, exp_cnt);
`endif
  endtask

  initial begin
    reset      = 1'b1;
    key_valid  = 1'b0;
    key_index  = '0;
    notch_r    = 1'b0;
    notch_m    = 1'b0;
    rotor_out  = '0;
    lamp_ready = 1'b0;
    #1;
    check("reset key_ready", key_ready, 1);
    check("reset rotate", {rotate_r, rotate_m, rotate_l}, 0);
    check("reset rotor_in", rotor_in, 0);
    check("reset lamp_valid", lamp_valid, 0);
    check("reset lamp_index", lamp_index, 0);
    check("reset lamp_error", lamp_error, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // A, return E(4): only the right rotor steps.
    run_key("basic", 5'd0, 1'b0, 1'b0, 26'h0000010, 26'h0000001, 1, 0, 0, 5'd4, 1'b0, 6, 3);
    handshake("basic");
    // H with middle notch: all three step together, return T(19).
    run_key("dstep_m", 5'd7, 1'b0, 1'b1, 26'h0080000, 26'h0000080, 1, 1, 1, 5'd19, 1'b0, 6, 3);
    handshake("dstep_m");
    // C with right notch: r and m step, return Z(25).
    run_key("step_r", 5'd2, 1'b1, 1'b0, 26'h2000000, 26'h0000004, 1, 1, 0, 5'd25, 1'b0, 6, 3);
    handshake("step_r");
    // Invalid key goes straight to PRESENT.
    run_key("invalid", 5'd27, 1'b1, 1'b1, 26'h0000001, 26'h0, 0, 0, 0, 5'd31, 1'b1, 1, 0);
    handshake("invalid");
    run_key("ret_two", 5'd5, 1'b0, 1'b0, 26'h0000003, 26'h0000020, 1, 0, 0, 5'd31, 1'b1, 6, 3);
    handshake("ret_two");
    run_key("ret_none", 5'd9, 1'b0, 1'b0, 26'h0, 26'h0000200, 1, 0, 0, 5'd31, 1'b1, 6, 3);
    handshake("ret_none");

    // Backpressure: hold off lamp_ready, a stray key must be ignored.
    run_key("bp", 5'd12, 1'b0, 1'b0, 26'h0000001, 26'h0001000, 1, 0, 0, 5'd0, 1'b0, 6, 3);
    begin
      int bad = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        key_valid = (c == 2);
        key_index = 5'd6;
        @(posedge clk);
        #1;
        if (lamp_valid !== 1'b1 || lamp_index !== 5'd0 || key_ready !== 1'b0 || rotate_r !== 1'b0)
          bad++;
      end
      key_valid = 1'b0;
      check("bp hold stable", bad, 0);
    end
    handshake("bp");
    begin
      int act = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        if (rotate_r || lamp_valid || !key_ready) act++;
      end
      check("bp stray key ignored", act, 0);
    end

    // Reset while DRIVE is active.
    @(negedge clk);
    rotor_out = 26'h0000002;
    key_index = 5'd3;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    begin
      int w = 0;
      while (rotor_in == 26'h0 && w < 10) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("mid reset reached DRIVE", rotor_in, 26'h0000008);
    end
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    check("mid reset rotor_in", rotor_in, 0);
    check("mid reset lamp_valid", lamp_valid, 0);
    check("mid reset key_ready", key_ready, 1);
`ifdef KEYER_CHAR_COUNT_EN
    check("mid reset char_count", char_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post reset key_ready", key_ready, 1);

    run_key("after_rst1", 5'd25, 1'b0, 1'b0, 26'h0000002, 26'h2000000, 1, 0, 0, 5'd1, 1'b0, 6, 3);
    handshake("after_rst1");
    run_key("after_rst2", 5'd1, 1'b0, 1'b1, 26'h0000400, 26'h0000002, 1, 1, 1, 5'd10, 1'b0, 6, 3);
    handshake("after_rst2");
    run_key("after_rst3", 5'd31, 1'b0, 1'b0, 26'h0000400, 26'h0, 0, 0, 0, 5'd31, 1'b1, 1, 0);
    handshake("after_rst3");
`ifdef KEYER_CHAR_COUNT_EN
    check("char_count three", char_count, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
